trigger_conditioner: RTL and testbench
======================================

Name: trigger_conditioner

Overview:
Input conditioning stage placed directly upstream of the reset/trigger manager. It synchronises and glitch-filters the external trigger, watchdog and instant-reset pins, then produces clean level signals for the manager's trigger, watchdog and instant_reset inputs. The trigger path has an arm/delay state machine so acquisition and DAC release start a programmable number of cycles after a qualified trigger edge. Status is packed into a 32-bit word for the AXI status register.

Parameters:
FILTER_WIDTH, 16, width of the glitch-filter length input and of the per-channel filter counters
DELAY_WIDTH, 32, width of the trigger delay input and of the delay counter

Ports:
clk  input  1  system clock, 125 MHz
peripheral_aresetn  input  1  asynchronous active-low reset
trigger_raw  input  1  external trigger pin, asynchronous
watchdog_raw  input  1  external watchdog toggle pin, asynchronous
instant_reset_raw  input  1  external instant-reset pin, asynchronous
arm  input  1  1 = trigger FSM may accept edges; 0 = forced to IDLE
filter_len  input  FILTER_WIDTH  consecutive stable cycles required before a filtered output changes
trigger_delay  input  DELAY_WIDTH  cycles between a qualified trigger edge and trigger_out rising
sts_clear  input  1  single-cycle pulse that clears the sticky status bits
trigger_out  output  1  conditioned trigger level, fed to the manager's trigger input
watchdog_out  output  1  filtered watchdog level
instant_reset_out  output  1  filtered instant-reset level
cond_sts  output  32  status word

Behaviour:
- Reset (async assert, sync release): all sync flops, filtered values, counters, FSM and sticky bits go to 0. trigger_out, watchdog_out and instant_reset_out are 0; cond_sts is 0.
- Synchroniser: each raw pin passes through a 2-FF synchroniser. Only the second stage is used downstream.
- Glitch filter, per channel:
  - The counter increments while sync != filtered value and clears to 0 when they are equal.
  - When the counter reaches filter_len, the filtered value takes the sync value and the counter clears.
  - filter_len = 0 means the filtered value follows sync with 1 cycle of delay.
  - The counter saturates and never wraps.
  - A filter_len change mid-count takes effect on the next compare.
  - Glitch: a run in which sync differs for at least 1 cycle but returns to the filtered value before qualifying.
- watchdog_out and instant_reset_out are registered copies of the filtered values. Raw-to-output latency is filter_len + 4 cycles.
- Trigger FSM, states IDLE=0, DELAY=1, ACTIVE=2; trigger_out is registered and is 1 only in ACTIVE:
  - IDLE: on a filtered trigger rising edge with arm=1, load the delay counter with trigger_delay and go to DELAY. If trigger_delay = 0, go straight to ACTIVE.
  - DELAY: decrement each cycle; when the counter reaches 1, go to ACTIVE. If the filtered trigger falls, go to IDLE and set the sticky abort bit.
  - ACTIVE: stay while the filtered trigger is high. On fall, go to IDLE, and trigger_out drops on the next cycle.
  - arm=0 in any state forces IDLE on the next cycle. This has priority over edges and does not set abort.
  - A rising edge already present when arm asserts is not accepted; a fresh edge is required.
- Latency from raw trigger rising edge to trigger_out rising edge: filter_len + trigger_delay + 4 cycles when trigger_delay >= 1, and filter_len + 4 cycles when trigger_delay = 0.
- cond_sts fields:
  - [1:0] FSM state
  - [2] sticky abort
  - [3] sticky "edge ignored": a rising edge arrived while not in IDLE, or while arm=0
  - [4] trigger_out
  - [5] watchdog_out
  - [6] instant_reset_out
  - [15:7] 0
  - [31:16] see the optional feature
- sts_clear clears bits [3:2]. If sts_clear coincides with a set event in the same cycle, the set wins.

Optional Feature:
TRIGGER_CONDITIONER_STATS_EN
- Defined:
  - cond_sts[23:16] is an 8-bit count of accepted triggers (entries to ACTIVE).
  - cond_sts[31:24] is an 8-bit count of glitches rejected across all three filters.
  - Both counters saturate at 255 and are cleared by sts_clear and by reset.
- Undefined: cond_sts[31:16] is tied to 0 and no counter logic is built.

Test Plan:
- Reset: reset with raw pins high, then release -> all outputs 0 until filters qualify; cond_sts = 0.
- Delayed trigger: filter_len=3, trigger_delay=10, arm=1, trigger_raw rises and is held -> trigger_out rises exactly 17 cycles later; trigger_raw falls -> trigger_out falls 3+4 cycles later.
- Glitch rejection: filter_len=5, a 4-cycle pulse on trigger_raw and on watchdog_raw -> no output change, FSM stays IDLE; with STATS_EN, cond_sts[31:24] = 2.
- Abort: trigger_delay=100, trigger falls at delay count 50 -> FSM returns to IDLE, trigger_out never rises, cond_sts[2] = 1; an sts_clear pulse -> bit 2 = 0.
- Disarm and no-delay path: arm=0 during ACTIVE -> trigger_out = 0 next cycle and cond_sts[2] stays 0; re-arm while trigger is held high -> no retrigger and cond_sts[3] stays 0; release, then a fresh edge with trigger_delay=0 and filter_len=0 -> trigger_out rises 4 cycles after the raw edge.
- Reset mid-DELAY: assert peripheral_aresetn low while the delay counter = 7 -> trigger_out and state return to 0 immediately (asynchronously); after release, the delay restarts in full on a new edge.

Source files
------------

// File: rtl/trigger_conditioner_if.sv
// trigger_conditioner_if
// Bundles the conditioner's pin inputs, configuration, status clear and
// conditioned outputs. The master side drives pins/configuration; the slave
// side is the conditioner itself.
interface trigger_conditioner_if #(
    parameter int FILTER_WIDTH = 16,
    parameter int DELAY_WIDTH  = 32
);
    logic                    trigger_raw;
    logic                    watchdog_raw;
    logic                    instant_reset_raw;
    logic                    arm;
    logic [FILTER_WIDTH-1:0] filter_len;
    logic [DELAY_WIDTH-1:0]  trigger_delay;
    logic                    sts_clear;
    logic                    trigger_out;
    logic                    watchdog_out;
    logic                    instant_reset_out;
    logic [31:0]             cond_sts;

    modport master (
        output trigger_raw, watchdog_raw, instant_reset_raw,
        output arm, filter_len, trigger_delay, sts_clear,
        input  trigger_out, watchdog_out, instant_reset_out, cond_sts
    );

    modport slave (
        input  trigger_raw, watchdog_raw, instant_reset_raw,
        input  arm, filter_len, trigger_delay, sts_clear,
        output trigger_out, watchdog_out, instant_reset_out, cond_sts
    );
endinterface

// File: rtl/trigger_conditioner.sv
// trigger_conditioner
// Synchronises and glitch-filters the trigger, watchdog and instant-reset pins
// and runs the arm/delay trigger state machine feeding the reset/trigger
// manager. Status is packed into cond_sts.
// Optional feature macro: TRIGGER_CONDITIONER_STATS_EN builds the accepted
// trigger and rejected glitch counters in cond_sts[31:16]; otherwise those
// bits are tied to 0.
module trigger_conditioner #(
    parameter int FILTER_WIDTH = 16,
    parameter int DELAY_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 peripheral_aresetn,
    trigger_conditioner_if.slave bus
);
    // Channel index: 0 = trigger, 1 = watchdog, 2 = instant reset
    localparam int NCH = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    logic [NCH-1:0]          raw;
    logic [NCH-1:0]          sync_meta;
    logic [NCH-1:0]          sync_q;
    logic [NCH-1:0]          filt_q;
    logic [NCH-1:0]          out_q;
    logic [FILTER_WIDTH-1:0] filt_cnt [NCH];

    state_t                  state;
    logic [DELAY_WIDTH-1:0]  delay_cnt;
    logic                    trig_out_q;
    logic                    trig_rise;

    logic                    abort_q;
    logic                    ignored_q;
    logic                    abort_set;
    logic                    ignored_set;

    logic [15:0]             stats_word;

    assign raw = {bus.instant_reset_raw, bus.watchdog_raw, bus.trigger_raw};

    // Two-flop synchronisers bring the asynchronous pins into the clk domain
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
        end
    end

    // Per-channel filter: a change is accepted once sync has differed for filter_len compares
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            filt_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                filt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] >= bus.filter_len) begin
                    filt_q[i]   <= sync_q[i];
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] != '1) begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Registered copies of the filtered levels; bit 0 doubles as the trigger edge reference
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            out_q <= '0;
        end else begin
            out_q <= filt_q;
        end
    end

    assign trig_rise   = filt_q[0] & ~out_q[0];
    assign abort_set   = bus.arm && (state == DELAY) && !filt_q[0];
    assign ignored_set = trig_rise && (!bus.arm || (state != IDLE));

    // Trigger FSM: arm gate, programmable delay after a qualified edge, active while held
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            state      <= IDLE;
            delay_cnt  <= '0;
            trig_out_q <= 1'b0;
        end else if (!bus.arm) begin
            state      <= IDLE;
            trig_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig_rise) begin
                        if (bus.trigger_delay == '0) begin
                            state      <= ACTIVE;
                            trig_out_q <= 1'b1;
                        end else begin
                            state     <= DELAY;
                            delay_cnt <= bus.trigger_delay;
                        end
                    end
                end
                DELAY: begin
                    if (!filt_q[0]) begin
                        state <= IDLE;
                    end else if (delay_cnt == DELAY_WIDTH'(1)) begin
                        state      <= ACTIVE;
                        trig_out_q <= 1'b1;
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!filt_q[0]) begin
                        state      <= IDLE;
                        trig_out_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    trig_out_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky abort / edge-ignored flags; a set event in the clear cycle wins
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            abort_q   <= 1'b0;
            ignored_q <= 1'b0;
        end else begin
            abort_q   <= abort_set   | (abort_q   & ~bus.sts_clear);
            ignored_q <= ignored_set | (ignored_q & ~bus.sts_clear);
        end
    end

`ifdef TRIGGER_CONDITIONER_STATS_EN
    logic [NCH-1:0] glitch;
    logic [1:0]     glitch_sum;
    logic [8:0]     glitch_next;
    logic           trig_accept;
    logic [7:0]     trig_cnt;
    logic [7:0]     glitch_cnt;

    // A glitch is a run that counted at least once and then fell back to the filtered value
    always_comb begin
        glitch = '0;
        for (int i = 0; i < NCH; i++) begin
            glitch[i] = (sync_q[i] == filt_q[i]) && (filt_cnt[i] != '0);
        end
        glitch_sum  = {1'b0, glitch[0]} + {1'b0, glitch[1]} + {1'b0, glitch[2]};
        glitch_next = {1'b0, glitch_cnt} + {7'b0, glitch_sum};
        trig_accept = bus.arm &&
                      (((state == IDLE) && trig_rise && (bus.trigger_delay == '0)) ||
                       ((state == DELAY) && filt_q[0] && (delay_cnt == DELAY_WIDTH'(1))));
    end

    // Saturating statistics counters, restarted by sts_clear
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            trig_cnt   <= '0;
            glitch_cnt <= '0;
        end else if (bus.sts_clear) begin
            trig_cnt   <= {7'b0, trig_accept};
            glitch_cnt <= {6'b0, glitch_sum};
        end else begin
            if (trig_cnt != 8'hFF) begin
                trig_cnt <= trig_cnt + {7'b0, trig_accept};
            end
            glitch_cnt <= glitch_next[8] ? 8'hFF : glitch_next[7:0];
        end
    end

    assign stats_word = {glitch_cnt, trig_cnt};
`else
    assign stats_word = '0;
`endif

    assign bus.trigger_out       = trig_out_q;
    assign bus.watchdog_out      = out_q[1];
    assign bus.instant_reset_out = out_q[2];
    assign bus.cond_sts          = {stats_word, 9'b0, out_q[2], out_q[1],
                                    trig_out_q, ignored_q, abort_q, state};
endmodule

// File: tb/tb_trigger_conditioner.sv
// tb_trigger_conditioner
// Directed bench for trigger_conditioner: reset, delayed trigger, glitch
// rejection, abort, disarm/no-delay path and reset during the delay.
// Define TRIGGER_CONDITIONER_STATS_EN to also check the statistics counters.
module tb_trigger_conditioner;
    localparam int FW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic peripheral_aresetn = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    trigger_conditioner_if #(.FILTER_WIDTH(FW), .DELAY_WIDTH(DW)) bus ();

    trigger_conditioner #(.FILTER_WIDTH(FW), .DELAY_WIDTH(DW)) dut (
        .clk                (clk),
        .peripheral_aresetn (peripheral_aresetn),
        .bus                (bus)
    );

    always #4 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        bus.sts_clear = 1'b1;
        tick();
        bus.sts_clear = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        bus.trigger_raw = 1'b1;
        bus.watchdog_raw = 1'b1;
        bus.instant_reset_raw = 1'b1;
        bus.arm = 1'b0;
        bus.filter_len = 16'd3;
        bus.trigger_delay = 32'd0;
        bus.sts_clear = 1'b0;
        peripheral_aresetn = 1'b0;
        repeat (3) tick();
        compared++;
        if ({bus.trigger_out, bus.watchdog_out, bus.instant_reset_out} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %b expected 000",
                     {bus.trigger_out, bus.watchdog_out, bus.instant_reset_out});
        end
        compared++;
        if (bus.cond_sts !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_sts: got %h expected 00000000", bus.cond_sts);
        end
        peripheral_aresetn = 1'b1;
        tick();
        n = 1;
        compared++;
        if (bus.cond_sts !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL post_release_sts: got %h expected 00000000", bus.cond_sts);
        end
        while (n < 50 && bus.watchdog_out !== 1'b1) begin
            tick();
            n++;
        end
        compared++;
        if (n !== 7) begin
            mismatched++;
            $display("[TB] FAIL watchdog_qualify_latency: got %0d expected 7", n);
        end
        compared++;
        if (bus.instant_reset_out !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL instant_reset_qualify: got %b expected 1", bus.instant_reset_out);
        end
        repeat (2) tick();
        compared++;
        if (bus.cond_sts[15:0] !== 16'h0068) begin
            mismatched++;
            $display("[TB] FAIL disarmed_edge_ignored: got %h expected 0068", bus.cond_sts[15:0]);
        end
        pulse_clear();
        compared++;
        if (bus.cond_sts[15:0] !== 16'h0060) begin
            mismatched++;
            $display("[TB] FAIL sticky_clear: got %h expected 0060", bus.cond_sts[15:0]);
        end
        bus.trigger_raw = 1'b0;
        bus.watchdog_raw = 1'b0;
        bus.instant_reset_raw = 1'b0;
        repeat (10) tick();
        compared++;
        if (bus.cond_sts !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL idle_after_release: got %h expected 00000000", bus.cond_sts);
        end
    endtask

    task automatic test_delayed_trigger();
        int n;
        bus.filter_len = 16'd3;
        bus.trigger_delay = 32'd10;
        bus.arm = 1'b1;
        pulse_clear();
        tick();
        bus.trigger_raw = 1'b1;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (bus.trigger_out === 1'b1) break;
        end
        compared++;
        if (n !== 17) begin
            mismatched++;
            $display("[TB] FAIL delayed_rise_latency: got %0d expected 17", n);
        end
        compared++;
        if (bus.cond_sts[4:0] !== 5'b10010) begin
            mismatched++;
            $display("[TB] FAIL active_sts: got %b expected 10010", bus.cond_sts[4:0]);
        end
`ifdef TRIGGER_CONDITIONER_STATS_EN
        compared++;
        if (bus.cond_sts[23:16] !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL accepted_count: got %0d expected 1", bus.cond_sts[23:16]);
        end
`else
        compared++;
        if (bus.cond_sts[31:16] !== 16'h0) begin
            mismatched++;
            $display("[TB] FAIL stats_tied_off: got %h expected 0000", bus.cond_sts[31:16]);
        end
`endif
        bus.trigger_raw = 1'b0;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (bus.trigger_out === 1'b0) break;
        end
        compared++;
        if (n !== 7) begin
            mismatched++;
            $display("[TB] FAIL delayed_fall_latency: got %0d expected 7", n);
        end
        compared++;
        if (bus.cond_sts[4:0] !== 5'b00000) begin
            mismatched++;
            $display("[TB] FAIL idle_after_fall: got %b expected 00000", bus.cond_sts[4:0]);
        end
    endtask

    task automatic test_glitch();
        int n;
        int changes;
        bus.filter_len = 16'd5;
        bus.trigger_delay = 32'd0;
        bus.arm = 1'b1;
        pulse_clear();
        bus.trigger_raw = 1'b1;
        bus.watchdog_raw = 1'b1;
        repeat (4) tick();
        bus.trigger_raw = 1'b0;
        bus.watchdog_raw = 1'b0;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.trigger_out !== 1'b0 || bus.watchdog_out !== 1'b0 ||
                bus.cond_sts[1:0] !== 2'd0 || bus.cond_sts[3] !== 1'b0) changes++;
        end
        compared++;
        if (changes !== 0) begin
            mismatched++;
            $display("[TB] FAIL glitch_rejected: got %0d disturbed cycles expected 0", changes);
        end
`ifdef TRIGGER_CONDITIONER_STATS_EN
        compared++;
        if (bus.cond_sts[31:24] !== 8'd2) begin
            mismatched++;
            $display("[TB] FAIL glitch_count: got %0d expected 2", bus.cond_sts[31:24]);
        end
`endif
        bus.watchdog_raw = 1'b1;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (n == 6) bus.watchdog_raw = 1'b0;
            if (bus.watchdog_out === 1'b1) break;
        end
        compared++;
        if (n !== 9) begin
            mismatched++;
            $display("[TB] FAIL min_pulse_qualifies: got %0d expected 9", n);
        end
        repeat (20) tick();
        compared++;
        if (bus.watchdog_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL watchdog_returns_low: got %b expected 0", bus.watchdog_out);
        end
`ifdef TRIGGER_CONDITIONER_STATS_EN
        compared++;
        if (bus.cond_sts[31:24] !== 8'd2) begin
            mismatched++;
            $display("[TB] FAIL glitch_count_after_valid: got %0d expected 2", bus.cond_sts[31:24]);
        end
`endif
    endtask

    task automatic test_abort();
        int n;
        int rose;
        bus.filter_len = 16'd2;
        bus.trigger_delay = 32'd100;
        bus.arm = 1'b1;
        bus.trigger_raw = 1'b1;
        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (bus.cond_sts[1:0] === 2'd1) break;
        end
        compared++;
        if (n !== 6) begin
            mismatched++;
            $display("[TB] FAIL delay_entry_latency: got %0d expected 6", n);
        end
        rose = 0;
        repeat (50) begin
            tick();
            if (bus.trigger_out !== 1'b0) rose++;
        end
        bus.trigger_raw = 1'b0;
        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (bus.trigger_out !== 1'b0) rose++;
            if (bus.cond_sts[1:0] === 2'd0) break;
        end
        compared++;
        if (n !== 6) begin
            mismatched++;
            $display("[TB] FAIL abort_latency: got %0d expected 6", n);
        end
        compared++;
        if (rose !== 0) begin
            mismatched++;
            $display("[TB] FAIL abort_no_trigger: got %0d high cycles expected 0", rose);
        end
        compared++;
        if (bus.cond_sts[3:2] !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL abort_sticky: got %b expected 01", bus.cond_sts[3:2]);
        end
        pulse_clear();
        compared++;
        if (bus.cond_sts[2] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_cleared: got %b expected 0", bus.cond_sts[2]);
        end
    endtask

    task automatic test_disarm_no_delay();
        int n;
        int rose;
        bus.filter_len = 16'd3;
        bus.trigger_delay = 32'd10;
        bus.arm = 1'b1;
        bus.trigger_raw = 1'b1;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (bus.trigger_out === 1'b1) break;
        end
        compared++;
        if (n !== 17) begin
            mismatched++;
            $display("[TB] FAIL disarm_setup_latency: got %0d expected 17", n);
        end
        bus.arm = 1'b0;
        tick();
        compared++;
        if (bus.cond_sts[4:0] !== 5'b00000) begin
            mismatched++;
            $display("[TB] FAIL disarm_forces_idle: got %b expected 00000", bus.cond_sts[4:0]);
        end
        bus.arm = 1'b1;
        rose = 0;
        repeat (20) begin
            tick();
            if (bus.trigger_out !== 1'b0) rose++;
        end
        compared++;
        if (rose !== 0 || bus.cond_sts[3:0] !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL rearm_no_retrigger: got %0d high cycles sts %b expected 0 and 0000",
                     rose, bus.cond_sts[3:0]);
        end
        bus.trigger_raw = 1'b0;
        repeat (10) tick();
        bus.filter_len = 16'd0;
        bus.trigger_delay = 32'd0;
        tick();
        bus.trigger_raw = 1'b1;
        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (bus.trigger_out === 1'b1) break;
        end
        compared++;
        if (n !== 4) begin
            mismatched++;
            $display("[TB] FAIL no_delay_rise_latency: got %0d expected 4", n);
        end
        compared++;
        if (bus.cond_sts[1:0] !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL no_delay_state: got %0d expected 2", bus.cond_sts[1:0]);
        end
        bus.trigger_raw = 1'b0;
        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (bus.trigger_out === 1'b0) break;
        end
        compared++;
        if (n !== 4) begin
            mismatched++;
            $display("[TB] FAIL no_delay_fall_latency: got %0d expected 4", n);
        end
    endtask

    task automatic test_reset_mid_delay();
        int n;
        bus.filter_len = 16'd2;
        bus.trigger_delay = 32'd20;
        bus.arm = 1'b1;
        repeat (5) tick();
        bus.trigger_raw = 1'b1;
        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (bus.cond_sts[1:0] === 2'd1) break;
        end
        compared++;
        if (n !== 6) begin
            mismatched++;
            $display("[TB] FAIL mid_delay_entry: got %0d expected 6", n);
        end
        repeat (13) tick();
        compared++;
        if (bus.cond_sts[4:0] !== 5'b00001) begin
            mismatched++;
            $display("[TB] FAIL still_delaying: got %b expected 00001", bus.cond_sts[4:0]);
        end
        #2;
        peripheral_aresetn = 1'b0;
        #1;
        compared++;
        if (bus.cond_sts !== 32'h0 || bus.trigger_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_clears: got sts %h out %b expected 00000000 and 0",
                     bus.cond_sts, bus.trigger_out);
        end
        bus.trigger_raw = 1'b0;
        repeat (3) tick();
        peripheral_aresetn = 1'b1;
        repeat (5) tick();
        bus.trigger_raw = 1'b1;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (bus.trigger_out === 1'b1) break;
        end
        compared++;
        if (n !== 26) begin
            mismatched++;
            $display("[TB] FAIL full_delay_after_reset: got %0d expected 26", n);
        end
        bus.trigger_raw = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_delayed_trigger();
        test_glitch();
        test_abort();
        test_disarm_no_delay();
        test_reset_mid_delay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: got no completion expected finish before 1000000");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
